// File: rtl/atm_light_estimator_pkg.sv
// atm_light_estimator_pkg
//   Shared constants for the atmospheric-light estimator: pixel width, default
//   frame geometry, the A_MIN floor default, FSM state encoding and a small
//   floor helper. Optional feature macro used by the design: ATM_LIGHT_SMOOTH_EN.
package atm_light_estimator_pkg;

    localparam int unsigned PIX_W     = 8;
    localparam int unsigned IMG_W_DEF = 640;
    localparam int unsigned IMG_H_DEF = 480;
    localparam logic [PIX_W-1:0] A_MIN_DEF = 8'd1;

    // FSM encoding kept as plain constants so older tools read it as-is
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    // Clamp a component from below so downstream dividers never see zero
    function automatic logic [PIX_W-1:0] floor_a(input logic [PIX_W-1:0] v,
                                                 input logic [PIX_W-1:0] m);
        return (v < m) ? m : v;
    endfunction

endpackage

// File: rtl/atm_light_iir.sv
// atm_light_iir
//   Per-channel temporal smoothing of atmospheric light (compiled only when
//   ATM_LIGHT_SMOOTH_EN is defined). Purely combinational:
//     o_a = i_first ? i_frame : (3*i_prev + i_frame + 2) >> 2
//   Ports:
//     i_prev  [7:0]  previous filtered value (before the A_MIN floor)
//     i_frame [7:0]  this frame's selected component
//     i_first        first frame since reset: pass i_frame straight through
//     o_a     [7:0]  filtered component
`ifdef ATM_LIGHT_SMOOTH_EN
module atm_light_iir
    import atm_light_estimator_pkg::*;
(
    input  logic [PIX_W-1:0] i_prev,
    input  logic [PIX_W-1:0] i_frame,
    input  logic             i_first,
    output logic [PIX_W-1:0] o_a
);
    // Max 3*255 + 255 + 2 = 1022, so 10 bits never overflow
    logic [9:0] w_sum;

    assign w_sum = 10'(i_prev) * 10'd3 + 10'(i_frame) + 10'd2;
    assign o_a   = i_first ? i_frame : w_sum[9:2];

endmodule
`endif

// File: rtl/atm_light_estimator.sv
// atm_light_estimator
//   Scans a frame of dark-channel windows, keeps the window with the largest
//   min_all (earliest wins on ties) and publishes its mr/mg/mb as atmospheric
//   light A one cycle after the frame's last beat.
//   Optional: ATM_LIGHT_SMOOTH_EN adds a per-channel temporal IIR on A.
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     in_valid, in_last     beat qualifier, end-of-frame marker
//     mr, mg, mb, min_all   per-window channel minima and dark value
//     a_r, a_g, a_b         published atmospheric light (floored at A_MIN)
//     a_idx                 raster index of the selected window
//     a_valid               one-cycle publish pulse
//     busy                  frame in progress
//     frame_err             sticky frame-length error
module atm_light_estimator
    import atm_light_estimator_pkg::*;
#(
    parameter int unsigned       IMG_W = IMG_W_DEF,
    parameter int unsigned       IMG_H = IMG_H_DEF,
    parameter logic [PIX_W-1:0]  A_MIN = A_MIN_DEF,
    parameter int unsigned       IDX_W = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [PIX_W-1:0] mr,
    input  logic [PIX_W-1:0] mg,
    input  logic [PIX_W-1:0] mb,
    input  logic [PIX_W-1:0] min_all,
    output logic [PIX_W-1:0] a_r,
    output logic [PIX_W-1:0] a_g,
    output logic [PIX_W-1:0] a_b,
    output logic [IDX_W-1:0] a_idx,
    output logic             a_valid,
    output logic             busy,
    output logic             frame_err
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMG_W * IMG_H - 1);

    logic [0:0]       r_state;
    logic [IDX_W-1:0] r_pix_cnt;
    logic [PIX_W-1:0] r_best_dark, r_best_r, r_best_g, r_best_b;
    logic [IDX_W-1:0] r_best_idx;

    logic             w_first, w_at_end, w_eof, w_take;
    logic [PIX_W-1:0] w_cand_r, w_cand_g, w_cand_b;
    logic [IDX_W-1:0] w_cand_idx;
    logic [PIX_W-1:0] w_fin_r, w_fin_g, w_fin_b;

    // In IDLE the counter is always 0, so the state alone marks the first beat
    assign w_first  = (r_state == ST_IDLE);
    assign w_at_end = (r_pix_cnt == LAST_IDX);
    assign w_eof    = in_valid && (in_last || w_at_end);
    assign w_take   = w_first || (min_all > r_best_dark);

    // Candidate including the current beat, so the end-of-frame beat competes too
    assign w_cand_r   = w_take ? mr        : r_best_r;
    assign w_cand_g   = w_take ? mg        : r_best_g;
    assign w_cand_b   = w_take ? mb        : r_best_b;
    assign w_cand_idx = w_take ? r_pix_cnt : r_best_idx;

`ifdef ATM_LIGHT_SMOOTH_EN
    logic             r_first_frame;
    logic [PIX_W-1:0] r_filt_r, r_filt_g, r_filt_b;

    atm_light_iir u_iir_r (.i_prev(r_filt_r), .i_frame(w_cand_r), .i_first(r_first_frame), .o_a(w_fin_r));
    atm_light_iir u_iir_g (.i_prev(r_filt_g), .i_frame(w_cand_g), .i_first(r_first_frame), .o_a(w_fin_g));
    atm_light_iir u_iir_b (.i_prev(r_filt_b), .i_frame(w_cand_b), .i_first(r_first_frame), .o_a(w_fin_b));

    // Filter history is kept unfloored; the floor only shapes what is published
    always_ff @(posedge clk) begin
        if (rst) begin
            r_first_frame <= 1'b1;
            r_filt_r      <= 8'hFF;
            r_filt_g      <= 8'hFF;
            r_filt_b      <= 8'hFF;
        end else if (w_eof) begin
            r_first_frame <= 1'b0;
            r_filt_r      <= w_fin_r;
            r_filt_g      <= w_fin_g;
            r_filt_b      <= w_fin_b;
        end
    end
`else
    assign w_fin_r = w_cand_r;
    assign w_fin_g = w_cand_g;
    assign w_fin_b = w_cand_b;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pix_cnt   <= '0;
            r_best_dark <= '0;
            r_best_r    <= '0;
            r_best_g    <= '0;
            r_best_b    <= '0;
            r_best_idx  <= '0;
            a_r         <= 8'hFF;
            a_g         <= 8'hFF;
            a_b         <= 8'hFF;
            a_idx       <= '0;
            a_valid     <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            a_valid <= 1'b0;
            if (in_valid) begin
                if (w_take) begin
                    r_best_dark <= min_all;
                    r_best_r    <= mr;
                    r_best_g    <= mg;
                    r_best_b    <= mb;
                    r_best_idx  <= r_pix_cnt;
                end
                if (w_eof) begin
                    r_state   <= ST_IDLE;
                    r_pix_cnt <= '0;
                    a_valid   <= 1'b1;
                    a_idx     <= w_cand_idx;
                    a_r       <= floor_a(w_fin_r, A_MIN);
                    a_g       <= floor_a(w_fin_g, A_MIN);
                    a_b       <= floor_a(w_fin_b, A_MIN);
                    // Early in_last, or full count without in_last
                    if (in_last != w_at_end)
                        frame_err <= 1'b1;
                end else begin
                    r_state   <= ST_ACCUM;
                    r_pix_cnt <= r_pix_cnt + 1'b1;
                end
            end
        end
    end

    assign busy = (r_state == ST_ACCUM);

endmodule

// File: tb/tb_atm_light_estimator.sv
module tb_atm_light_estimator;
    localparam int IDX_W = 4;

    logic             clk = 1'b0;
    logic             rst, in_valid, in_last;
    logic [7:0]       mr, mg, mb, min_all;
    logic [7:0]       a_r, a_g, a_b;
    logic [IDX_W-1:0] a_idx;
    logic             a_valid, busy, frame_err;

    int tests = 0;
    int fails = 0;
    int pulses = 0;

    atm_light_estimator #(.IMG_W(4), .IMG_H(2), .A_MIN(8'd1), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
        .mr(mr), .mg(mg), .mb(mb), .min_all(min_all),
        .a_r(a_r), .a_g(a_g), .a_b(a_b), .a_idx(a_idx),
        .a_valid(a_valid), .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1 time unit after the edge, count publishes
    task automatic tick();
        @(posedge clk);
        #1;
        if (a_valid) pulses++;
    endtask

    task automatic beat(input logic [7:0] r, g, b, m, input logic last);
        in_valid = 1'b1; in_last = last;
        mr = r; mg = g; mb = b; min_all = m;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic chk_a(input string tag, input int r, g, b, idx);
        chk({tag, "_r"},   a_r,   r);
        chk({tag, "_g"},   a_g,   g);
        chk({tag, "_b"},   a_b,   b);
        chk({tag, "_idx"}, a_idx, idx);
    endtask

    initial begin
        logic [7:0] m1 [8];
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        mr = '0; mg = '0; mb = '0; min_all = '0;
        do_reset();

        chk_a("rst", 255, 255, 255, 0);
        chk("rst_valid", a_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", frame_err, 0);

`ifdef ATM_LIGHT_SMOOTH_EN
        // Temporal filter: first frame loads directly, second is blended
        for (int i = 0; i < 8; i++) beat(8'd100, 8'd100, 8'd100, 8'd100, i == 7);
        chk("iir1_valid", a_valid, 1);
        chk_a("iir1", 100, 100, 100, 0);
        for (int i = 0; i < 8; i++) beat(8'd200, 8'd200, 8'd200, 8'd200, i == 7);
        chk("iir2_valid", a_valid, 1);
        chk_a("iir2", 125, 125, 125, 0);
`else
        // Test 1: max at idx2, tie at idx4 must be ignored
        m1[0] = 10; m1[1] = 20; m1[2] = 200; m1[3] = 50;
        m1[4] = 200; m1[5] = 30; m1[6] = 0; m1[7] = 5;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2)      beat(8'd210, 8'd220, 8'd200, m1[i], 1'b0);
            else if (i == 4) beat(8'd250, 8'd240, 8'd200, m1[i], 1'b0);
            else             beat(m1[i], m1[i], m1[i], m1[i], i == 7);
            if (i == 0) chk("t1_busy", busy, 1);
        end
        chk("t1_pulses_before", pulses - int'(a_valid), 0);
        chk("t1_valid", a_valid, 1);
        chk_a("t1", 210, 220, 200, 2);
        chk("t1_err", frame_err, 0);
        idle(1);
        chk("t1_pulse_len", a_valid, 0);
        chk("t1_busy_end", busy, 0);
        chk_a("t1_hold", 210, 220, 200, 2);

        // Test 2: all-zero frame floors at A_MIN
        for (int i = 0; i < 8; i++) beat(8'd0, 8'd0, 8'd0, 8'd0, i == 7);
        chk("t2_valid", a_valid, 1);
        chk_a("t2", 1, 1, 1, 0);

        // Test 3: early in_last on 5th beat
        m1[0] = 5; m1[1] = 9; m1[2] = 3; m1[3] = 9; m1[4] = 7;
        pulses = 0;
        for (int i = 0; i < 5; i++) beat(m1[i] + 8'd10, m1[i] + 8'd20, m1[i], m1[i], i == 4);
        chk("t3_valid", a_valid, 1);
        chk("t3_pulses", pulses, 1);
        chk_a("t3", 19, 29, 9, 1);
        chk("t3_err", frame_err, 1);
        idle(1);
        for (int i = 0; i < 8; i++) beat(8'd40 + 8'(i), 8'd50, 8'd60, 8'd40 + 8'(i), i == 7);
        chk("t3b_valid", a_valid, 1);
        chk_a("t3b", 47, 50, 60, 7);
        chk("t3b_err_sticky", frame_err, 1);

        // Test 4: back-to-back, next frame starts in the publish cycle
        for (int i = 0; i < 8; i++) beat(8'd50 + 8'(i), 8'd60 + 8'(i), 8'd3, 8'd3, i == 7);
        chk("t4a_valid", a_valid, 1);
        chk_a("t4a", 50, 60, 3, 0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) beat(8'd120, 8'd110, 8'd100, 8'd100, 1'b1);
            else        beat(8'(i + 1), 8'(i + 1), 8'(i + 1), 8'(i + 1), 1'b0);
            if (i == 0) chk("t4b_busy", busy, 1);
            if (i < 7) idle($urandom_range(0, 2));
        end
        chk("t4b_valid", a_valid, 1);
        chk("t4b_pulses", pulses, 1);
        chk_a("t4b", 120, 110, 100, 7);

        // Test 5: reset mid-frame discards the partial frame
        idle(1);
        pulses = 0;
        for (int i = 0; i < 3; i++) beat(8'd250, 8'd250, 8'd250, 8'd250, 1'b0);
        do_reset();
        chk("t5_pulses", pulses, 0);
        chk_a("t5", 255, 255, 255, 0);
        chk("t5_busy", busy, 0);
        chk("t5_err", frame_err, 0);
        // Full count without in_last closes the frame and flags an error
        for (int i = 0; i < 8; i++) beat(8'd30, 8'd20, 8'd10 + 8'(i), 8'd10 + 8'(i), 1'b0);
        chk("t5b_valid", a_valid, 1);
        chk_a("t5b", 30, 20, 17, 7);
        chk("t5b_err", frame_err, 1);
        chk("t5b_busy", busy, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/atm_light_estimator.md
Name: atm_light_estimator

Overview:
- Downstream consumer of the dark-channel stage's per-window outputs: channel minima mr/mg/mb and the dark value min_all.
- Per frame, finds the window with the maximum min_all (the haziest/brightest dark-channel pixel) and captures its mr/mg/mb as atmospheric light A.
- Publishes A once per frame for the transmission-estimation and recovery stages.

Parameters:
- IMG_W, 640, pixels per line
- IMG_H, 480, lines per frame
- A_MIN, 8'd1, floor applied to each published A component (prevents divide-by-zero downstream)
- IDX_W, 19, width of pixel index; must satisfy 2**IDX_W >= IMG_W*IMG_H

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  mr/mg/mb/min_all valid this cycle
- in_last  in  1  qualifies the last window of the frame (sampled only with in_valid)
- mr  in  8  red 3x3 minimum
- mg  in  8  green 3x3 minimum
- mb  in  8  blue 3x3 minimum
- min_all  in  8  dark value, min(mr,mg,mb)
- a_r  out  8  atmospheric light, red
- a_g  out  8  atmospheric light, green
- a_b  out  8  atmospheric light, blue
- a_idx  out  IDX_W  raster index of the selected window in the last frame
- a_valid  out  1  one-cycle pulse: new A published
- busy  out  1  frame in progress (FSM in ACCUM)
- frame_err  out  1  sticky: frame length differed from IMG_W*IMG_H

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high; it wins over all other inputs.
- Reset values: a_r = a_g = a_b = 8'hFF; a_idx = 0; a_valid = 0; busy = 0; frame_err = 0; state = IDLE; pix_cnt = 0; best_dark = 0; first_frame = 1.
- FSM states:
  - IDLE: waiting for the first beat of a frame.
  - ACCUM: frame in progress.
- FSM transitions:
  - IDLE -> ACCUM on in_valid without end-of-frame.
  - ACCUM -> IDLE on end-of-frame beat.
  - IDLE -> IDLE on a single-beat frame, which is processed fully.
- End-of-frame beat: in_valid && (in_last || pix_cnt == IMG_W*IMG_H-1), whichever occurs first.
- Accumulation:
  - First beat of a frame loads best_dark/best_r/g/b/best_idx from inputs unconditionally.
  - Each later beat replaces the stored values iff min_all > best_dark (strict). On ties the earliest pixel wins.
  - pix_cnt increments per accepted beat and clears to 0 on the end-of-frame beat.
- Gaps: in_valid low holds all state; there is no timeout.
- Comparison includes the end-of-frame beat itself.
- Publish:
  - Cycle after the end-of-frame beat: a_valid = 1 for exactly one cycle.
  - In that cycle, a_r/g/b = max(candidate, A_MIN) and a_idx = selected index.
  - Outputs hold until the next publish. Latency is 1 cycle from the last beat.
- Back-to-back frames: a beat arriving in the publish cycle is the first pixel of the next frame. No bubble is required.
- frame_err is set when:
  - in_last arrives with pix_cnt != IMG_W*IMG_H-1, or
  - the count reaches IMG_W*IMG_H-1 without in_last.
  - In both cases the frame is still closed and published. frame_err clears only on rst.
- Reset mid-frame: the partial frame is discarded with no publish, and outputs return to reset values.
- Widths: all comparisons are unsigned 8-bit; pix_cnt and a_idx are IDX_W bits.

Optional Feature:
- Macro: ATM_LIGHT_SMOOTH_EN.
- Defined: temporal IIR across frames, per channel A = (3*A_prev + A_frame + 2) >> 2.
  - Compute in 10-bit intermediates and truncate to 8 bits; no overflow is possible.
  - The first frame after reset loads A_frame directly (first_frame flag).
  - A_MIN is applied after filtering.
  - Publish latency stays 1 cycle.
- Undefined: A = A_frame each frame; no first_frame register and no filter logic.

Decomposition:
- Shared package: PIX_W = 8, the IMG_W/IMG_H defaults, the FSM state encoding (IDLE, ACCUM), and the A_MIN default.
- One natural sub-module: atm_light_iir. It is the per-channel smoothing filter, instantiated three times, and exists only under ATM_LIGHT_SMOOTH_EN.

Test Plan:
1. Reset then a 4x2 frame (IMG_W=4, IMG_H=2), min_all = 10,20,200,50,200,30,0,5 with mr/mg/mb at idx2 = 210/220/200 -> a_valid once, cycle after the 8th beat, with A = 210/220/200, a_idx = 2 (tie at idx4 ignored), frame_err = 0.
2. All-zero frame -> A = 1/1/1 (A_MIN floor), a_idx = 0.
3. in_last on the 5th beat of a 4x2 frame -> publish after 5 beats, frame_err = 1 and sticky; the next correct frame publishes normally.
4. Back-to-back frames with a beat in the publish cycle, plus random in_valid gaps -> second frame's A is correct; pix_cnt is not corrupted.
5. rst asserted mid-frame after 3 beats -> no a_valid; A = FF/FF/FF; the next frame is evaluated from scratch.
6. ATM_LIGHT_SMOOTH_EN defined, frame1 A = 100, frame2 A_frame = 200 per channel -> publishes 100, then (300+200+2)>>2 = 125.
